polyvec_uniform_gamma1_ctrl: RTL and testbench
==============================================

// Module: polyvec_uniform_gamma1_ctrl
// PURPOSE
//   Sequencer for one shared poly_uniform_gamma1 core: computes the mask vector
//   y = ExpandMask(seed, kappa) by running the core L times with nonce = L*kappa+i.
//   Latches the seed and kappa, drives the core's level start/done handshake,
//   and streams each 8192-bit polynomial to a consumer with a valid/ready handshake.
//   Sits between the signing FSM and poly_uniform_gamma1.
// PARAMETERS
//   L            4       polynomials per vector (4/5/7 for Dilithium2/3/5)
//   POLY_W       8192    polynomial width in bits (256 coeffs x 32 b)
//   TIMEOUT_CYC  20000   max cycles to wait for core_done per polynomial
// PORTS
//   clock        in   1       system clock, rising edge
//   reset        in   1       synchronous, active-high
//   start        in   1       request; sampled only in IDLE
//   seed         in   512     rho' seed; latched on accepted start
//   kappa        in   16      mask counter; latched on accepted start
//   busy         out  1       high from accepted start until DONE/ERR exit
//   done         out  1       1-cycle pulse after last poly is accepted
//   error        out  1       1-cycle pulse on core timeout
//   poly_valid   out  1       poly_data/poly_index valid
//   poly_ready   in   1       consumer accepts when valid&ready on an edge
//   poly_index   out  3       index i of presented poly (0..L-1)
//   poly_data    out  POLY_W  latched core output
//   core_start   out  1       level start to core
//   core_seed    out  512     latched seed (stable whole operation)
//   core_nonce   out  16      (L*kappa + i) mod 2^16
//   core_done    in   1       core completion level
//   core_a_out   in   POLY_W  core result, valid while core_done high
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, i=0; reset has priority over every event.
//   States: IDLE, RUN, HOLD, CLR, FIN, ERR.
//   IDLE: start=1 -> latch seed, kappa; i<=0; busy<=1; -> RUN.
//   RUN: core_start=1, core_nonce=L*kappa+i (16-bit wrap, truncate product).
//     core_done=1 sampled -> poly_data<=core_a_out, poly_index<=i, core_start<=0,
//     poly_valid<=1 -> HOLD. Watchdog counts cycles in RUN; reaching TIMEOUT_CYC
//     -> core_start<=0, error pulse -> ERR.
//   HOLD: poly_valid held, poly_data/poly_index stable until valid&ready.
//     On handshake: poly_valid<=0; -> CLR.
//   CLR: core_start=0; wait core_done==0 (core may clear during HOLD; then 1 cycle).
//     Then if i==L-1 -> FIN, else i<=i+1, watchdog<=0 -> RUN.
//     Guarantees core_start low >=1 cycle between polys.
//   FIN: done=1 for one cycle, busy<=0 -> IDLE.
//   ERR: busy<=0, poly_valid=0 -> IDLE next cycle (error is the 1-cycle pulse).
//   start while busy: ignored, latched seed/kappa unchanged.
//   poly_ready while poly_valid=0: ignored.
//   Latency per poly: core latency + 1 (capture) + consumer stall + >=1 (CLR).
//   Reset mid-operation: next edge core_start=0, poly_valid=0, IDLE; no done/error.
// TESTING
//   T1: L=4, kappa=0, seed=73c0...0d06, ready tied 1 -> nonces 0,1,2,3 in order;
//       poly_index 0..3; done exactly 1 pulse; each poly_data == core_a_out.
//   T2: kappa=123, L=4 -> first core_nonce=492, last 495; poly 0 matches the
//       standalone poly_uniform_gamma1 run with nonce 492 on same seed.
//   T3: ready low 50 cycles on poly 1 -> poly_valid/data/index stable, core_start
//       stays 0, no nonce advance; release -> sequence completes, one done.
//   T4: kappa=16'h4000, L=4 -> core_nonce wraps to 0x0000..0x0003.
//   T5: core model never asserts done, TIMEOUT_CYC=100 -> error pulse at cycle
//       100 of RUN, core_start drops, busy=0, no done; new start then succeeds.
//   T6: reset asserted during HOLD of poly 2 -> next cycle all outputs 0; start
//       pulse while busy ignored (kappa change not reflected in nonces).

Source files
------------

// File: rtl/polyvec_uniform_gamma1_ctrl.sv
// Sequencer that runs one shared poly_uniform_gamma1 core L times to build the
// mask vector y, streaming each captured polynomial out over valid/ready.
module polyvec_uniform_gamma1_ctrl #(
  parameter int L           = 4,
  parameter int POLY_W      = 8192,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [511:0]      seed,
  input  logic [15:0]       kappa,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              poly_valid,
  input  logic              poly_ready,
  output logic [2:0]        poly_index,
  output logic [POLY_W-1:0] poly_data,
  output logic              core_start,
  output logic [511:0]      core_seed,
  output logic [15:0]       core_nonce,
  input  logic              core_done,
  input  logic [POLY_W-1:0] core_a_out
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      LAST    = 3'(L - 1);
  localparam logic [15:0]     L16     = 16'(L);

  typedef enum logic [2:0] {IDLE, RUN, HOLD, CLR, FIN, ERR} state_t;

  state_t          state;
  logic [2:0]      idx;
  logic [WD_W-1:0] wdog;
  logic [15:0]     kappa_q;

  // Nonce is L*kappa + i taken modulo 2^16; the product is truncated, not saturated.
  function automatic logic [15:0] nonce_of(input logic [15:0] k, input logic [2:0] i);
    return L16 * k + {13'd0, i};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      wdog       <= '0;
      kappa_q    <= 16'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      poly_valid <= 1'b0;
      poly_index <= 3'd0;
      poly_data  <= '0;
      core_start <= 1'b0;
      core_seed  <= '0;
      core_nonce <= 16'd0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            core_seed  <= seed;
            kappa_q    <= kappa;
            idx        <= 3'd0;
            wdog       <= '0;
            busy       <= 1'b1;
            core_start <= 1'b1;
            core_nonce <= nonce_of(kappa, 3'd0);
            state      <= RUN;
          end
        end
        RUN: begin
          if (core_done) begin
            poly_data  <= core_a_out;
            poly_index <= idx;
            poly_valid <= 1'b1;
            core_start <= 1'b0;
            state      <= HOLD;
          end else if (wdog == WD_LAST) begin
            core_start <= 1'b0;
            error      <= 1'b1;
            state      <= ERR;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        HOLD: begin
          if (poly_ready) begin
            poly_valid <= 1'b0;
            state      <= CLR;
          end
        end
        // Hold off the next start until the core has dropped done from the last run.
        CLR: begin
          if (!core_done) begin
            if (idx == LAST) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              idx        <= idx + 3'd1;
              wdog       <= '0;
              core_start <= 1'b1;
              core_nonce <= nonce_of(kappa_q, idx + 3'd1);
              state      <= RUN;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          busy       <= 1'b0;
          poly_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polyvec_uniform_gamma1_ctrl.sv
// Directed bench for polyvec_uniform_gamma1_ctrl with a behavioural core model
// whose output depends on seed and nonce, so each captured poly identifies its run.
module tb_polyvec_uniform_gamma1_ctrl;
  localparam int L   = 4;
  localparam int PW  = 256;
  localparam int TO  = 100;
  localparam int LAT = 5;

  logic          clock = 1'b0;
  logic          reset, start, poly_ready, core_done;
  logic [511:0]  seed, core_seed;
  logic [15:0]   kappa, core_nonce;
  logic          busy, done, error, poly_valid, core_start;
  logic [2:0]    poly_index;
  logic [PW-1:0] poly_data, core_a_out;

  polyvec_uniform_gamma1_ctrl #(.L(L), .POLY_W(PW), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .seed(seed), .kappa(kappa),
    .busy(busy), .done(done), .error(error), .poly_valid(poly_valid),
    .poly_ready(poly_ready), .poly_index(poly_index), .poly_data(poly_data),
    .core_start(core_start), .core_seed(core_seed), .core_nonce(core_nonce),
    .core_done(core_done), .core_a_out(core_a_out));

  always #5 clock = ~clock;

  function automatic logic [PW-1:0] poly_of(input logic [511:0] s, input logic [15:0] n);
    logic [PW-1:0] r;
    for (int k = 0; k < PW/32; k++)
      r[k*32 +: 32] = s[(k*32)%512 +: 32] ^ {n, 16'(k * 16'h1357)};
    return r;
  endfunction

  // Core model: done rises LAT cycles after start; optionally lingers slow_clr cycles.
  logic hang;
  int   slow_clr, lat_cnt, clr_cnt;
  initial begin core_done = 1'b0; core_a_out = '0; lat_cnt = 0; clr_cnt = 0; end
  always @(posedge clock) begin
    if (!core_start) begin
      lat_cnt <= 0;
      if (clr_cnt > 0) clr_cnt <= clr_cnt - 1;
      else core_done <= 1'b0;
    end else if (!hang && !core_done) begin
      if (lat_cnt == LAT) begin
        core_done  <= 1'b1;
        core_a_out <= poly_of(core_seed, core_nonce);
        clr_cnt    <= slow_clr;
      end else lat_cnt <= lat_cnt + 1;
    end
  end

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 512'(busy), 512'(0));
    chk({tag, "_done"}, 512'(done), 512'(0));
    chk({tag, "_error"}, 512'(error), 512'(0));
    chk({tag, "_valid"}, 512'(poly_valid), 512'(0));
    chk({tag, "_core_start"}, 512'(core_start), 512'(0));
    chk({tag, "_index"}, 512'(poly_index), 512'(0));
    chk({tag, "_data"}, 512'(poly_data), 512'(0));
    chk({tag, "_nonce"}, 512'(core_nonce), 512'(0));
    chk({tag, "_seed"}, core_seed, 512'(0));
  endtask

  typedef struct {
    string        name;
    logic [15:0]  kappa;
    logic [511:0] seed;
    int           stall_idx;
    int           stall_len;
    int           slow;
    logic [15:0]  n0;
  } vec_t;

  localparam logic [511:0] SEED1 = {16'h73c0, 480'h0, 16'h0d06};
  localparam logic [511:0] SEED2 = {64{8'hA5}} ^ {16{32'h01234567}};

  vec_t vecs[5];

  task automatic run_op(input vec_t v);
    int got = 0, nst = 0, dones = 0, errs = 0, cyc = 0, stall = 0;
    logic prev_cs = 1'b0;
    logic [PW-1:0] snap_d = '0;
    logic [2:0] snap_i = 3'd0;
    logic [15:0] snap_n = 16'd0;
    slow_clr   = v.slow;
    poly_ready = 1'b1;
    @(negedge clock);
    seed = v.seed; kappa = v.kappa; start = 1'b1;
    @(negedge clock);
    start = 1'b0; seed = ~v.seed; kappa = 16'hAAAA;
    chk({v.name, "_busy_on"}, 512'(busy), 512'(1));
    chk({v.name, "_seed_latch"}, core_seed, v.seed);
    while (got < L && cyc < 3000) begin
      if (core_start && !prev_cs) begin
        chk({v.name, "_nonce"}, 512'(core_nonce), 512'(16'(v.n0 + 16'(nst))));
        nst++;
      end
      prev_cs = core_start;
      if (done) dones++;
      if (error) errs++;
      if (poly_valid) begin
        if (got == v.stall_idx && stall < v.stall_len) begin
          if (stall == 0) begin
            snap_d = poly_data; snap_i = poly_index; snap_n = core_nonce;
          end else begin
            chk({v.name, "_stall_data"}, 512'(poly_data), 512'(snap_d));
            chk({v.name, "_stall_index"}, 512'(poly_index), 512'(snap_i));
            chk({v.name, "_stall_nonce"}, 512'(core_nonce), 512'(snap_n));
            chk({v.name, "_stall_core_start"}, 512'(core_start), 512'(0));
          end
          poly_ready = 1'b0;
          stall++;
        end else poly_ready = 1'b1;
        if (poly_ready) begin
          chk({v.name, "_index"}, 512'(poly_index), 512'(got));
          chk({v.name, "_data"}, 512'(poly_data), 512'(poly_of(v.seed, 16'(v.n0 + 16'(got)))));
          got++;
        end
      end
      @(negedge clock);
      cyc++;
    end
    if (got < L) chk({v.name, "_polys_timeout"}, 512'(got), 512'(L));
    for (int k = 0; k < 10; k++) begin
      if (done) dones++;
      if (error) errs++;
      @(negedge clock);
    end
    chk({v.name, "_starts"}, 512'(nst), 512'(L));
    chk({v.name, "_done_pulses"}, 512'(dones), 512'(1));
    chk({v.name, "_errors"}, 512'(errs), 512'(0));
    chk({v.name, "_busy_off"}, 512'(busy), 512'(0));
  endtask

  initial begin
    int n, nst, cyc, dones;
    logic prev_cs;
    vecs[0] = '{"t1_k0",     16'd0,     SEED1, -1, 0,  0, 16'd0};
    vecs[1] = '{"t2_k123",   16'd123,   SEED1, -1, 0,  0, 16'd492};
    vecs[2] = '{"t3_stall",  16'd7,     SEED2,  1, 50, 0, 16'd28};
    vecs[3] = '{"t4_wrap",   16'h4000,  SEED2, -1, 0,  0, 16'h0000};
    vecs[4] = '{"kffff_clr", 16'hFFFF,  SEED1, -1, 0,  3, 16'hFFFC};

    reset = 1'b1; start = 1'b0; seed = '0; kappa = '0; poly_ready = 1'b0;
    hang = 1'b0; slow_clr = 0;
    repeat (3) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    foreach (vecs[i]) run_op(vecs[i]);

    // Timeout: core never finishes.
    hang = 1'b1; slow_clr = 0;
    @(negedge clock);
    seed = SEED2; kappa = 16'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("t5_core_start", 512'(core_start), 512'(1));
    n = 0; dones = 0;
    while (!error && n < 300) begin
      @(negedge clock);
      if (done) dones++;
      n++;
    end
    chk("t5_error_cycle", 512'(n), 512'(TO));
    chk("t5_core_start_drop", 512'(core_start), 512'(0));
    @(negedge clock);
    chk("t5_error_pulse", 512'(error), 512'(0));
    chk("t5_busy", 512'(busy), 512'(0));
    chk("t5_no_done", 512'(dones), 512'(0));
    hang = 1'b0;
    run_op(vecs[0]);

    // Reset during HOLD of poly 2, with a start attempt while busy.
    poly_ready = 1'b1;
    @(negedge clock);
    seed = SEED1; kappa = 16'd2; start = 1'b1;
    @(negedge clock);
    kappa = 16'd100;
    @(negedge clock);
    start = 1'b0;
    nst = 1; prev_cs = 1'b1; cyc = 0;
    while (!(poly_valid && poly_index == 3'd2) && cyc < 1000) begin
      if (core_start && !prev_cs) begin
        chk("t6_nonce", 512'(core_nonce), 512'(16'(16'd8 + 16'(nst))));
        nst++;
      end
      prev_cs = core_start;
      @(negedge clock);
      cyc++;
    end
    poly_ready = 1'b0;
    chk("t6_reached_poly2", 512'(poly_valid && poly_index == 3'd2), 512'(1));
    chk("t6_nonce_poly2", 512'(core_nonce), 512'(16'd10));
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_zero("t6_reset");
    reset = 1'b0;
    dones = 0;
    repeat (5) begin
      @(negedge clock);
      if (done || error || busy) dones++;
    end
    chk("t6_quiet_after_reset", 512'(dones), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
